// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// Multiply/divide sequencer for the EX stage of the 5-stage MIPS core.
// Recognises the MULT/MULTU/DIV/DIVU alucontrol codes, runs the operation and
// holds the front of the pipeline until the HI/LO pair is ready.
// - Multiply: one busy cycle, then a DONE cycle.
// - Divide: 32-iteration restoring divider on operand magnitudes, with the
//   sign fixup applied on the last iteration.
// - Divide by zero: skips straight to DONE with HI=dividend, LO=all ones.
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst           synchronous, active-high reset
//   valid_i       EX stage holds a real (non-bubble) instruction
//   alucontrol_i  EX-stage ALU op code
//   srca_i        rs value (multiplicand / dividend)
//   srcb_i        rt value (multiplier / divisor)
//   flush_i       cancel the EX instruction
//   stall_o       hold IF/ID/EX this cycle (combinational)
//   busy_o        sequencer is not idle
//   done_o        one-cycle pulse: hi_o/lo_o valid, write HI/LO
//   hi_o          product high word / remainder
//   lo_o          product low word / quotient
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter logic [7:0] OP_MULT  = 8'b00011000,
    parameter logic [7:0] OP_MULTU = 8'b00011001,
    parameter logic [7:0] OP_DIV   = 8'b00011010,
    parameter logic [7:0] OP_DIVU  = 8'b00011011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  alucontrol_i,
    input  logic [31:0] srca_i,
    input  logic [31:0] srcb_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] opa_q;      // multiplicand, or dividend magnitude shifting into the quotient
    logic [31:0] opb_q;      // multiplier, or divisor magnitude
    logic [31:0] rem_q;      // partial remainder
    logic        sgn_q;      // multiply is signed
    logic        qneg_q;     // quotient must be negated at the end
    logic        rneg_q;     // remainder must be negated at the end
    logic [4:0]  cnt_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Two's-complement negate and magnitude of a 32-bit word. The magnitude of
    // 0x80000000 is 0x80000000, which is correct when read as unsigned.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

    // Op decode
    logic is_mul_op;
    logic is_div_op;
    logic is_sgn_op;
    logic start;

    assign is_mul_op = (alucontrol_i == OP_MULT) || (alucontrol_i == OP_MULTU);
    assign is_div_op = (alucontrol_i == OP_DIV)  || (alucontrol_i == OP_DIVU);
    assign is_sgn_op = (alucontrol_i == OP_MULT) || (alucontrol_i == OP_DIV);
    assign start     = (state_q == IDLE) && valid_i && !flush_i && (is_mul_op || is_div_op);

    // Multiply: sign-extend to 64 bits for MULT so the low 64 bits of the
    // product equal the signed product; zero-extend for MULTU.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;

    assign mul_a = {{32{sgn_q & opa_q[31]}}, opa_q};
    assign mul_b = {{32{sgn_q & opb_q[31]}}, opb_q};
    assign prod  = mul_a * mul_b;

    // One restoring-division step. The shifted remainder needs 33 bits, but
    // the difference always fits in 32 because the old remainder < divisor.
    logic [32:0] rem_sh;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    always_comb begin
        rem_sh = {rem_q, opa_q[31]};
        rem_d  = rem_sh[31:0];
        quo_d  = {opa_q[30:0], 1'b0};
        if (rem_sh >= {1'b0, opb_q}) begin
            rem_d = rem_sh[31:0] - opb_q;
            quo_d = {opa_q[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= 5'd0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (is_mul_op) begin
                            opa_q   <= srca_i;
                            opb_q   <= srcb_i;
                            sgn_q   <= is_sgn_op;
                            state_q <= MUL;
                        end else if (srcb_i == 32'd0) begin
                            hi_q    <= srca_i;
                            lo_q    <= 32'hFFFF_FFFF;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            opa_q   <= is_sgn_op ? abs32(srca_i) : srca_i;
                            opb_q   <= is_sgn_op ? abs32(srcb_i) : srcb_i;
                            rem_q   <= 32'd0;
                            cnt_q   <= 5'd0;
                            qneg_q  <= is_sgn_op && (srca_i[31] ^ srcb_i[31]);
                            rneg_q  <= is_sgn_op && srca_i[31];
                            state_q <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        hi_q    <= prod[63:32];
                        lo_q    <= prod[31:0];
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DIV: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        opa_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 5'd1;
                        // Last step: publish the sign-corrected result directly.
                        if (cnt_q == 5'd31) begin
                            hi_q    <= rneg_q ? neg32(rem_d) : rem_d;
                            lo_q    <= qneg_q ? neg32(quo_d) : quo_d;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The finished instruction is still in EX; ignore inputs.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_o = start || (state_q == MUL) || (state_q == DIV);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
// Directed bench for the multiply/divide sequencer. Inputs change 1 ns after a
// rising edge; outputs are sampled on the falling edge. Cycle 1 is the cycle in
// which an operation is first presented to the idle sequencer.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

    localparam logic [7:0] OP_MULT  = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_DIV   = 8'b00011010;
    localparam logic [7:0] OP_DIVU  = 8'b00011011;
    localparam logic [7:0] OP_ADD   = 8'b00100000;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [7:0]  alucontrol_i;
    logic [31:0] srca_i;
    logic [31:0] srcb_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks;
    int failures;

    mdu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .alucontrol_i (alucontrol_i),
        .srca_i       (srca_i),
        .srcb_i       (srcb_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one md op and follow it until done_o; the op stays on the inputs
    // (the instruction is held in EX) until the task returns after DONE.
    task automatic run_op(input string tag, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int est, input int edone);
        int nst;
        int dcyc;
        nst  = 0;
        dcyc = 0;
        @(posedge clk);
        #1;
        valid_i      = 1'b1;
        alucontrol_i = op;
        srca_i       = a;
        srcb_i       = b;
        flush_i      = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_o) begin
                dcyc = c;
                break;
            end
            if (stall_o) nst++;
        end
        check_eq({tag, "_stall_cycles"}, 64'(nst), 64'(est));
        check_eq({tag, "_done_cycle"}, 64'(dcyc), 64'(edone));
        check_eq({tag, "_hi"}, {32'd0, hi_o}, {32'd0, ehi});
        check_eq({tag, "_lo"}, {32'd0, lo_o}, {32'd0, elo});
    endtask

    // Bubbles in EX: no stall and no done pulse.
    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            flush_i = 1'b0;
            rst     = 1'b0;
            @(negedge clk);
            check_eq({tag, "_done"}, {63'd0, done_o}, 64'd0);
            check_eq({tag, "_stall"}, {63'd0, stall_o}, 64'd0);
        end
    endtask

    // Start a DIV and leave it in flight just before iteration 10 (cycle 12).
    task automatic start_div_to_iter10(input string tag);
        @(posedge clk);
        #1;
        valid_i      = 1'b1;
        alucontrol_i = OP_DIV;
        srca_i       = 32'd1000;
        srcb_i       = 32'd3;
        flush_i      = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check_eq({tag, "_inflight_stall"}, {63'd0, stall_o}, 64'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        valid_i      = 1'b0;
        alucontrol_i = 8'd0;
        srca_i       = 32'd0;
        srcb_i       = 32'd0;
        flush_i      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", {63'd0, stall_o}, 64'd0);
        check_eq("rst_busy",  {63'd0, busy_o},  64'd0);
        check_eq("rst_done",  {63'd0, done_o},  64'd0);
        check_eq("rst_hi",    {32'd0, hi_o},    64'd0);
        check_eq("rst_lo",    {32'd0, lo_o},    64'd0);
        idle("post_rst", 2);

        // Multiply, signed and unsigned
        run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 3);
        idle("mult_post", 1);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 2, 3);
        idle("multu_post", 1);

        // Divide, signed and unsigned, and divide by zero
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 34);
        idle("div_post", 1);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 34);
        idle("divu_post", 1);
        run_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1, 2);
        idle("divz_post", 1);

        // Flush mid-divide keeps the prior MULT result
        run_op("mult_3_4", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 2, 3);
        idle("mult34_post", 1);
        start_div_to_iter10("flush");
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check_eq("flush_cycle_stall", {63'd0, stall_o}, 64'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        check_eq("flush_next_busy",  {63'd0, busy_o},  64'd0);
        check_eq("flush_next_stall", {63'd0, stall_o}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) seen++;
            @(negedge clk);
        end
        check_eq("flush_no_done", 64'(seen), 64'd0);
        check_eq("flush_hi", {32'd0, hi_o}, 64'd0);
        check_eq("flush_lo", {32'd0, lo_o}, 64'd12);

        // Reset mid-divide clears the outputs
        start_div_to_iter10("rstdiv");
        @(posedge clk);
        #1;
        rst     = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstdiv_busy",  {63'd0, busy_o},  64'd0);
        check_eq("rstdiv_stall", {63'd0, stall_o}, 64'd0);
        check_eq("rstdiv_done",  {63'd0, done_o},  64'd0);
        check_eq("rstdiv_hi",    {32'd0, hi_o},    64'd0);
        check_eq("rstdiv_lo",    {32'd0, lo_o},    64'd0);
        idle("rstdiv_post", 3);

        // Signed overflow corner, then a MULTU starting right after DONE
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 34);
        run_op("b2b_multu", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 2, 3);
        idle("b2b_post", 2);

        // Flush in the start cycle suppresses the start
        @(posedge clk);
        #1;
        valid_i      = 1'b1;
        alucontrol_i = OP_MULT;
        srca_i       = 32'd7;
        srcb_i       = 32'd7;
        flush_i      = 1'b1;
        @(negedge clk);
        check_eq("startflush_stall", {63'd0, stall_o}, 64'd0);
        idle("startflush_post", 2);
        check_eq("startflush_lo", {32'd0, lo_o}, 64'd15);

        // Non-md op is ignored
        @(posedge clk);
        #1;
        valid_i      = 1'b1;
        alucontrol_i = OP_ADD;
        srca_i       = 32'd9;
        srcb_i       = 32'd9;
        flush_i      = 1'b0;
        @(negedge clk);
        check_eq("add_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        check_eq("add_busy",  {63'd0, busy_o},  64'd0);
        check_eq("add_done",  {63'd0, done_o},  64'd0);
        check_eq("add_stall2", {63'd0, stall_o}, 64'd0);
        idle("add_post", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
